template_match_ctrl: RTL
========================

Name: template_match_ctrl

Overview:
Sequencer for the template-matching datapath (linebuffer -> sad -> linecounter). It pulls a binary image from a pixel source one bit per handshake and shifts each bit into the linebuffer. It tracks raster position and aligns the SAD result with its window coordinates. It stops on the first window whose SAD is below a latched threshold, otherwise scans the full frame while reporting the minimum-SAD window.

Parameters:
IMG_W, 640, image width in pixels
IMG_H, 480, image height in pixels
TPL_W, 40, template width
TPL_H, 100, template height
SAD_W, 12, width of SAD score / threshold
SAD_LAT, 2, cycles from a linebuffer shift to the matching valid sad_in (>=1)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse, begin a scan (ignored unless IDLE)
abort  in  1  return to IDLE from any state next cycle
threshold  in  SAD_W  hit threshold, latched on accepted start
pix_valid  in  1  source has a pixel on pix_data
pix_data  in  1  image pixel, raster order
pix_ready  out  1  controller accepts pixel this cycle
lb_d  out  1  bit to linebuffer (= pix_data)
lb_shift  out  1  linebuffer shift enable (= pix_valid & pix_ready)
sad_in  in  SAD_W  score from linecounter
busy  out  1  scan in progress
done  out  1  one-cycle pulse, scan finished
found  out  1  sticky: hit occurred in last scan
match_x  out  clog2(IMG_W)  top-left x of hit window
match_y  out  clog2(IMG_H)  top-left y of hit window
best_sad  out  SAD_W  minimum SAD of last scan
best_x, best_y  out  as match_x/match_y  top-left of minimum window

Behaviour:
- Reset (rst=0, async): state IDLE; all outputs 0 except best_sad = all-ones; counters 0.
- States: IDLE, SCAN, DRAIN, DONE.
- IDLE: pix_ready=0. start=1 & abort=0 -> SCAN; latch threshold; clear found, match_*, best_*, col, row, pipeline valids. start and abort together -> stay IDLE.
- SCAN: pix_ready=1. Each shift advances col; col wraps IMG_W-1 -> 0 and increments row. window_valid = (row >= TPL_H-1) & (col >= TPL_W-1) for the pixel just shifted.
- window_valid, x = col-(TPL_W-1) and y = row-(TPL_H-1) enter a SAD_LAT-deep delay line. The delay line advances every cycle, not only on shifts. sad_in is sampled when the delay-line output is valid.
- Sampled score s < threshold (strict) -> found=1, match_x/y = delayed coords, -> DONE. pix_ready drops the same cycle. Delay-line contents are discarded.
- Sampled score s < best_sad (strict) -> update best_sad/x/y; ties keep the earlier window. Also update on the hit cycle.
- Shift of last pixel (col=IMG_W-1, row=IMG_H-1) -> DRAIN; pix_ready=0.
- DRAIN: wait until the delay line is empty, evaluating results as in SCAN; a hit -> DONE with found=1; empty -> DONE with found=0.
- A hit on the same cycle as the last-pixel shift -> DONE (hit wins).
- DONE: done=1 for one cycle -> IDLE. found, match_*, best_* hold until the next accepted start.
- abort in SCAN/DRAIN/DONE -> IDLE next cycle, no done pulse. Results keep their partial values.
- busy = 1 in SCAN and DRAIN.
- pix_valid low stalls the scan; the coordinate pipeline keeps advancing, so no false valids occur.
- Latency: first valid score at SAD_LAT cycles after the shift of pixel ((TPL_H-1)*IMG_W + TPL_W-1).

Decomposition:
- Shared package tm_pkg: SAD_W, coordinate width functions (clog2-based), state encoding constants.
- One sub-module raster_counter: col/row counters with wrap, last-pixel flag and window_valid.
- The delay line and FSM stay in the top module.

Test Plan:
- Params IMG_W=8, IMG_H=6, TPL_W=3, TPL_H=2, SAD_LAT=1; sad model returns 100 except window (4,2) returns 5; threshold=10 -> found=1, match_x=4, match_y=2, done pulses once, busy drops the same cycle.
- Same image, threshold=5 (strict compare) -> full scan, found=0, best_sad=5, best=(4,2), done after 48 shifts + drain.
- Windows (1,0) and (5,3) both score 20; threshold=0 -> best=(1,0) (tie keeps first), best_sad=20.
- pix_valid toggled 1,0,0,1... -> exactly 48 shifts, coordinates unchanged vs. the unstalled run.
- abort mid-SCAN at pixel 20 -> IDLE next cycle, no done, pix_ready=0; start then rescans from (0,0).
- rst asserted mid-SCAN -> outputs at reset values immediately; start accepted after release.

Source files
------------

// File: rtl/tm_pkg.sv
// ============================================================================
//  Module      : tm_pkg
//  Description : Shared types and helpers for the template-match sequencer
//  Revision    : 1.0
// ============================================================================
`default_nettype none

package tm_pkg;

  // Default width of SAD scores and the hit threshold
  localparam int SAD_W_DEF = 12;

  // Width of a coordinate able to address 0..n-1 (never narrower than 1 bit)
  function automatic int coord_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

`default_nettype wire

// File: rtl/raster_counter.sv
// ============================================================================
//  Module      : raster_counter
//  Description : Raster column/row tracker; flags last pixel and valid windows
//                for the pixel currently being shifted.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module raster_counter
  import tm_pkg::*;
#(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  parameter int TPL_W = 40,
  parameter int TPL_H = 100,
  localparam int XW = coord_w(IMG_W),
  localparam int YW = coord_w(IMG_H)
) (
  input  logic          clk,
  input  logic          rst,          // asynchronous, active low
  input  logic          clr_i,        // restart from (0,0)
  input  logic          adv_i,        // one pixel shifted this cycle
  output logic          last_o,       // current pixel is the frame's last one
  output logic          win_valid_o,  // current pixel completes a full window
  output logic [XW-1:0] win_x_o,      // window top-left x
  output logic [YW-1:0] win_y_o       // window top-left y
);

  logic [XW-1:0] col_q, col_d;
  logic [YW-1:0] row_q, row_d;

  // Next position: wrap column at line end, row at frame end
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (clr_i) begin
      col_d = '0;
      row_d = '0;
    end else if (adv_i) begin
      if (col_q == XW'(IMG_W - 1)) begin
        col_d = '0;
        row_d = (row_q == YW'(IMG_H - 1)) ? '0 : row_q + YW'(1);
      end else begin
        col_d = col_q + XW'(1);
      end
    end
  end

  // Position registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  assign last_o      = (col_q == XW'(IMG_W - 1)) && (row_q == YW'(IMG_H - 1));
  assign win_valid_o = (row_q >= YW'(TPL_H - 1)) && (col_q >= XW'(TPL_W - 1));
  assign win_x_o     = col_q - XW'(TPL_W - 1);
  assign win_y_o     = row_q - YW'(TPL_H - 1);

endmodule

`default_nettype wire

// File: rtl/template_match_ctrl.sv
// ============================================================================
//  Module      : template_match_ctrl
//  Description : Sequencer for linebuffer -> sad -> linecounter. Streams the
//                image, aligns SAD scores with window coordinates, stops on
//                the first score below threshold and tracks the minimum.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module template_match_ctrl
  import tm_pkg::*;
#(
  parameter int IMG_W   = 640,
  parameter int IMG_H   = 480,
  parameter int TPL_W   = 40,
  parameter int TPL_H   = 100,
  parameter int SAD_W   = SAD_W_DEF,
  parameter int SAD_LAT = 2,
  localparam int XW = coord_w(IMG_W),
  localparam int YW = coord_w(IMG_H)
) (
  input  logic             clk,
  input  logic             rst,        // asynchronous, active low
  input  logic             start,
  input  logic             abort,
  input  logic [SAD_W-1:0] threshold,
  input  logic             pix_valid,
  input  logic             pix_data,
  output logic             pix_ready,
  output logic             lb_d,
  output logic             lb_shift,
  input  logic [SAD_W-1:0] sad_in,
  output logic             busy,
  output logic             done,
  output logic             found,
  output logic [XW-1:0]    match_x,
  output logic [YW-1:0]    match_y,
  output logic [SAD_W-1:0] best_sad,
  output logic [XW-1:0]    best_x,
  output logic [YW-1:0]    best_y
);

  state_e state_q, state_d;
  logic   start_acc;

  logic [SAD_W-1:0] thr_q;
  logic             found_q;
  logic [XW-1:0]    match_x_q, best_x_q;
  logic [YW-1:0]    match_y_q, best_y_q;
  logic [SAD_W-1:0] best_sad_q;

  // Coordinate delay line; its output lines up with sad_in
  logic [SAD_LAT-1:0] dl_v_q;
  logic [XW-1:0]      dl_x_q [SAD_LAT];
  logic [YW-1:0]      dl_y_q [SAD_LAT];

  logic          w_active, w_shift, w_out_v, w_hit, w_better, w_flush, w_dl_empty;
  logic          w_last, w_win_valid;
  logic [XW-1:0] w_win_x;
  logic [YW-1:0] w_win_y;

  assign w_active   = (state_q == ST_SCAN) || (state_q == ST_DRAIN);
  assign w_out_v    = dl_v_q[SAD_LAT-1] && w_active;
  assign w_hit      = w_out_v && (sad_in < thr_q);
  assign w_better   = w_out_v && (sad_in < best_sad_q);
  // A hit freezes the source the same cycle, so no pixel slips past the match
  assign pix_ready  = (state_q == ST_SCAN) && !w_hit;
  assign w_shift    = pix_valid && pix_ready;
  assign w_flush    = w_hit || abort || !w_active;
  assign w_dl_empty = (dl_v_q == '0);

  raster_counter #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .TPL_W (TPL_W),
    .TPL_H (TPL_H)
  ) u_raster (
    .clk         (clk),
    .rst         (rst),
    .clr_i       (start_acc),
    .adv_i       (w_shift),
    .last_o      (w_last),
    .win_valid_o (w_win_valid),
    .win_x_o     (w_win_x),
    .win_y_o     (w_win_y)
  );

  // Next-state logic; abort overrides everything outside IDLE
  always_comb begin
    state_d   = state_q;
    start_acc = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          state_d   = ST_SCAN;
          start_acc = 1'b1;
        end
      end
      ST_SCAN: begin
        if (w_hit)                 state_d = ST_DONE;
        else if (w_shift && w_last) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (w_hit || w_dl_empty) state_d = ST_DONE;
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    if (abort && (state_q != ST_IDLE)) state_d = ST_IDLE;
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // Delay line advances every cycle; emptied outside an active scan or on hit
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dl_v_q <= '0;
      for (int i = 0; i < SAD_LAT; i++) begin
        dl_x_q[i] <= '0;
        dl_y_q[i] <= '0;
      end
    end else begin
      dl_v_q[0] <= w_shift && w_win_valid && !w_flush;
      dl_x_q[0] <= w_win_x;
      dl_y_q[0] <= w_win_y;
      for (int i = 1; i < SAD_LAT; i++) begin
        dl_v_q[i] <= dl_v_q[i-1] && !w_flush;
        dl_x_q[i] <= dl_x_q[i-1];
        dl_y_q[i] <= dl_y_q[i-1];
      end
    end
  end

  // Result registers: cleared on accepted start, frozen by abort
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      thr_q      <= '0;
      found_q    <= 1'b0;
      match_x_q  <= '0;
      match_y_q  <= '0;
      best_sad_q <= '1;
      best_x_q   <= '0;
      best_y_q   <= '0;
    end else if (start_acc) begin
      thr_q      <= threshold;
      found_q    <= 1'b0;
      match_x_q  <= '0;
      match_y_q  <= '0;
      best_sad_q <= '1;
      best_x_q   <= '0;
      best_y_q   <= '0;
    end else if (!abort) begin
      if (w_hit) begin
        found_q   <= 1'b1;
        match_x_q <= dl_x_q[SAD_LAT-1];
        match_y_q <= dl_y_q[SAD_LAT-1];
      end
      if (w_better) begin
        best_sad_q <= sad_in;
        best_x_q   <= dl_x_q[SAD_LAT-1];
        best_y_q   <= dl_y_q[SAD_LAT-1];
      end
    end
  end

  assign lb_d     = pix_data;
  assign lb_shift = w_shift;
  assign busy     = w_active;
  assign done     = (state_q == ST_DONE);
  assign found    = found_q;
  assign match_x  = match_x_q;
  assign match_y  = match_y_q;
  assign best_sad = best_sad_q;
  assign best_x   = best_x_q;
  assign best_y   = best_y_q;

endmodule

`default_nettype wire
